muldiv_hilo_ctrl: RTL and testbench

- Sequencer for the shared multi-cycle multiply/divide unit and owner of the architectural HI/LO register pair.
- Sits beside the execute-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and issues a one-cycle start to the iterative unit.
- Stalls the pipeline while the unit runs, holds the 64-bit result until the pipeline can retire it, then commits HI/LO; cancels cleanly on flush.

---
 rtl/muldiv_hilo_ctrl_pkg.sv | 28 ++
 rtl/muldiv_hilo_ctrl_hilo_reg.sv | 37 +++
 rtl/muldiv_hilo_ctrl.sv | 118 +++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: the operation codes,
// the FSM states and the default operand width.
package md_pkg;

  localparam int unsigned MD_DATA_W = 32;

  typedef enum logic [2:0] {
    MD_NONE = 3'd0,
    MULT    = 3'd1,
    MULTU   = 3'd2,
    DIV     = 3'd3,
    DIVU    = 3'd4,
    MTHI    = 3'd5,
    MTLO    = 3'd6
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // True for the operations that occupy the iterative unit.
  function automatic logic md_uses_unit(md_op_t op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_hilo_reg.sv
// Architectural HI/LO register pair with independent write enables.
// Define MULDIV_HILO_FWD_EN to bypass a same-cycle write onto hi_o/lo_o.
module hilo_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_hi_we,
  input  logic [DATA_W-1:0] i_hi_d,
  input  logic              i_lo_we,
  input  logic [DATA_W-1:0] i_lo_d,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (i_hi_we) r_hi <= i_hi_d;
      if (i_lo_we) r_lo <= i_lo_d;
    end
  end

`ifdef MULDIV_HILO_FWD_EN
  assign o_hi = i_hi_we ? i_hi_d : r_hi;
  assign o_lo = i_lo_we ? i_lo_d : r_lo;
`else
  assign o_hi = r_hi;
  assign o_lo = r_lo;
`endif

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Sequencer for the shared iterative mul/div unit; owns HI/LO through hilo_reg.
// MULDIV_HILO_FWD_EN (see hilo_reg) enables same-cycle HI/LO forwarding.
module muldiv_hilo_ctrl
  import md_pkg::*;
#(
  parameter int unsigned DATA_W = MD_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid_i,
  input  md_op_t              op_i,
  input  logic [DATA_W-1:0]   src_a_i,
  input  logic [DATA_W-1:0]   src_b_i,
  input  logic                stall_i,
  input  logic                flush_i,
  output logic                unit_start_o,
  output logic                unit_div_o,
  output logic                unit_signed_o,
  output logic [DATA_W-1:0]   unit_a_o,
  output logic [DATA_W-1:0]   unit_b_o,
  output logic                unit_annul_o,
  input  logic                unit_ready_i,
  input  logic [2*DATA_W-1:0] unit_result_i,
  output logic                busy_o,
  output logic                hilo_we_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o
);

  md_state_t           r_state;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_div;
  logic                r_signed;
  logic [2*DATA_W-1:0] r_res;

  logic              w_idle, w_run, w_done;
  logic              w_accept, w_mthi, w_mtlo, w_capture, w_commit;
  logic              w_hi_we, w_lo_we;
  logic [DATA_W-1:0] w_hi_d, w_lo_d;

  assign w_idle = (r_state == IDLE);
  assign w_run  = (r_state == RUN);
  assign w_done = (r_state == DONE);

  assign w_accept  = w_idle & op_valid_i & md_uses_unit(op_i) & ~flush_i;
  assign w_mthi    = w_idle & op_valid_i & ~stall_i & ~flush_i & (op_i == MTHI);
  assign w_mtlo    = w_idle & op_valid_i & ~stall_i & ~flush_i & (op_i == MTLO);
  // Flush outranks a same-cycle ready: the result is dropped with the instruction.
  assign w_capture = w_run & ~flush_i & unit_ready_i;
  assign w_commit  = w_done & ~stall_i & ~flush_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_div    <= 1'b0;
      r_signed <= 1'b0;
      r_res    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a      <= src_a_i;
            r_b      <= src_b_i;
            r_div    <= (op_i == DIV) || (op_i == DIVU);
            r_signed <= (op_i == MULT) || (op_i == DIV);
            r_state  <= RUN;
          end
        end
        RUN: begin
          if (flush_i) begin
            r_state <= IDLE;
          end else if (unit_ready_i) begin
            r_res   <= unit_result_i;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (flush_i || !stall_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign unit_start_o  = w_accept;
  assign unit_div_o    = r_div;
  assign unit_signed_o = r_signed;
  assign unit_a_o      = r_a;
  assign unit_b_o      = r_b;
  assign unit_annul_o  = w_run & flush_i;
  assign busy_o        = w_accept | w_run;
  assign hilo_we_o     = w_commit | w_mthi | w_mtlo;

  assign w_hi_we = w_commit | w_mthi;
  assign w_lo_we = w_commit | w_mtlo;
  assign w_hi_d  = w_commit ? r_res[2*DATA_W-1:DATA_W] : src_a_i;
  assign w_lo_d  = w_commit ? r_res[DATA_W-1:0]        : src_a_i;

  hilo_reg #(
    .DATA_W (DATA_W)
  ) u_hilo_reg (
    .clk     (clk),
    .rst     (rst),
    .i_hi_we (w_hi_we),
    .i_hi_d  (w_hi_d),
    .i_lo_we (w_lo_we),
    .i_lo_d  (w_lo_d),
    .o_hi    (hi_o),
    .o_lo    (lo_o)
  );

  logic w_unused_capture;
  assign w_unused_capture = w_capture;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl; the bench plays the mul/div unit.
module tb_muldiv_hilo_ctrl;
  import md_pkg::*;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           op_valid_i;
  md_op_t         op_i;
  logic [W-1:0]   src_a_i, src_b_i;
  logic           stall_i, flush_i;
  logic           unit_start_o, unit_div_o, unit_signed_o, unit_annul_o;
  logic [W-1:0]   unit_a_o, unit_b_o;
  logic           unit_ready_i;
  logic [2*W-1:0] unit_result_i;
  logic           busy_o, hilo_we_o;
  logic [W-1:0]   hi_o, lo_o;

  int n_pass  = 0;
  int n_total = 0;
  int we_cnt  = 0;
  int we0;
  int busy_cycles;

  always #5 clk = ~clk;

  always @(negedge clk) if (hilo_we_o === 1'b1) we_cnt++;

  muldiv_hilo_ctrl #(.DATA_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .op_valid_i    (op_valid_i),
    .op_i          (op_i),
    .src_a_i       (src_a_i),
    .src_b_i       (src_b_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .unit_start_o  (unit_start_o),
    .unit_div_o    (unit_div_o),
    .unit_signed_o (unit_signed_o),
    .unit_a_o      (unit_a_o),
    .unit_b_o      (unit_b_o),
    .unit_annul_o  (unit_annul_o),
    .unit_ready_i  (unit_ready_i),
    .unit_result_i (unit_result_i),
    .busy_o        (busy_o),
    .hilo_we_o     (hilo_we_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    rst = 1'b0; op_valid_i = 1'b0; op_i = MD_NONE;
    src_a_i = '0; src_b_i = '0; stall_i = 1'b0; flush_i = 1'b0;
    unit_ready_i = 1'b0; unit_result_i = '0;

    // Reset
    tick; tick;
    chk("rst_busy", busy_o, 0);
    chk("rst_start", unit_start_o, 0);
    chk("rst_annul", unit_annul_o, 0);
    chk("rst_we", hilo_we_o, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_ua", unit_a_o, 0);
    rst = 1'b1;
    tick;

    // DIV 100/7, ready in the 33rd RUN cycle
    we0 = we_cnt; busy_cycles = 0;
    op_valid_i = 1'b1; op_i = DIV; src_a_i = 32'd100; src_b_i = 32'd7;
    settle;
    chk("div_start", unit_start_o, 1);
    if (busy_o) busy_cycles++;
    tick;
    src_a_i = 32'hAAAA_AAAA; src_b_i = 32'h0;
    for (int i = 1; i <= 33; i++) begin
      unit_ready_i  = (i == 33);
      unit_result_i = (i == 33) ? {32'd2, 32'd14} : 64'h0;
      settle;
      if (busy_o) busy_cycles++;
      if (i == 1) begin
        chk("div_ua_frozen", unit_a_o, 100);
        chk("div_ub_frozen", unit_b_o, 7);
        chk("div_unit_div", unit_div_o, 1);
        chk("div_unit_signed", unit_signed_o, 1);
        chk("div_no_restart", unit_start_o, 0);
      end
      tick;
    end
    unit_ready_i = 1'b0; unit_result_i = '0;
    settle;
    chk("div_busy_cycles", busy_cycles, 34);
    chk("div_done_busy", busy_o, 0);
    chk("div_done_no_accept", unit_start_o, 0);
    chk("div_done_we", hilo_we_o, 1);
`ifdef MULDIV_HILO_FWD_EN
    chk("div_done_hi_fwd", hi_o, 2);
`else
    chk("div_done_hi_reg", hi_o, 0);
`endif
    tick;
    op_valid_i = 1'b0;
    settle;
    chk("div_hi", hi_o, 2);
    chk("div_lo", lo_o, 14);
    chk("div_we_after", hilo_we_o, 0);
    chk("div_we_pulses", we_cnt - we0, 1);

    // MULT -1 * 2 with 3 stall cycles in DONE
    op_valid_i = 1'b1; op_i = MULT; src_a_i = 32'hFFFF_FFFF; src_b_i = 32'd2;
    settle;
    chk("mult_start", unit_start_o, 1);
    tick;
    unit_ready_i = 1'b1; unit_result_i = 64'hFFFF_FFFF_FFFF_FFFE;
    settle;
    chk("mult_signed", unit_signed_o, 1);
    chk("mult_div", unit_div_o, 0);
    chk("mult_ua", unit_a_o, 32'hFFFF_FFFF);
    tick;
    unit_ready_i = 1'b0; unit_result_i = '0; stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle;
      chk("mult_stall_we", hilo_we_o, 0);
      chk("mult_stall_busy", busy_o, 0);
      tick;
    end
    chk("mult_stall_hi_held", hi_o, 2);
    stall_i = 1'b0;
    settle;
    chk("mult_commit_we", hilo_we_o, 1);
    tick;
    op_valid_i = 1'b0;
    settle;
    chk("mult_hi", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo", lo_o, 32'hFFFF_FFFE);

    // DIVU flushed in RUN cycle 10, then a late ready
    we0 = we_cnt;
    op_valid_i = 1'b1; op_i = DIVU; src_a_i = 32'd50; src_b_i = 32'd0;
    settle;
    tick;
    for (int i = 1; i <= 10; i++) begin
      flush_i = (i == 10);
      settle;
      chk("divu_annul", unit_annul_o, (i == 10) ? 1 : 0);
      if (i == 1) begin
        chk("divu_unit_div", unit_div_o, 1);
        chk("divu_unsigned", unit_signed_o, 0);
      end
      if (i == 10) chk("divu_flush_busy", busy_o, 1);
      tick;
    end
    flush_i = 1'b0; op_valid_i = 1'b0;
    settle;
    chk("divu_annul_single", unit_annul_o, 0);
    chk("divu_idle_busy", busy_o, 0);
    unit_ready_i = 1'b1; unit_result_i = 64'h1111_2222_3333_4444;
    tick;
    unit_ready_i = 1'b0; unit_result_i = '0;
    settle;
    tick;
    chk("divu_hi_kept", hi_o, 32'hFFFF_FFFF);
    chk("divu_lo_kept", lo_o, 32'hFFFF_FFFE);
    chk("divu_no_we", we_cnt - we0, 0);
    chk("divu_late_busy", busy_o, 0);

    // MTHI then MTLO back-to-back
    we0 = we_cnt;
    op_valid_i = 1'b1; op_i = MTHI; src_a_i = 32'hDEAD_BEEF;
    settle;
    chk("mthi_we", hilo_we_o, 1);
    chk("mthi_busy", busy_o, 0);
    chk("mthi_start", unit_start_o, 0);
`ifdef MULDIV_HILO_FWD_EN
    chk("mthi_hi_fwd", hi_o, 32'hDEAD_BEEF);
`else
    chk("mthi_hi_reg", hi_o, 32'hFFFF_FFFF);
`endif
    tick;
    op_i = MTLO; src_a_i = 32'h1234_5678;
    settle;
    chk("mthi_hi", hi_o, 32'hDEAD_BEEF);
    chk("mtlo_we", hilo_we_o, 1);
    chk("mtlo_busy", busy_o, 0);
    tick;
    op_valid_i = 1'b0;
    settle;
    chk("mtlo_lo", lo_o, 32'h1234_5678);
    chk("mt_we_pulses", we_cnt - we0, 2);

    // MTHI under stall does not write
    op_valid_i = 1'b1; op_i = MTHI; src_a_i = 32'h1; stall_i = 1'b1;
    settle;
    chk("mthi_stall_we", hilo_we_o, 0);
    tick;
    stall_i = 1'b0; op_valid_i = 1'b0;
    settle;
    chk("mthi_stall_hi", hi_o, 32'hDEAD_BEEF);

    // MTLO 0x55: same-cycle visibility depends on forwarding
    op_valid_i = 1'b1; op_i = MTLO; src_a_i = 32'h55;
    settle;
`ifdef MULDIV_HILO_FWD_EN
    chk("mtlo55_same_cycle", lo_o, 32'h55);
`else
    chk("mtlo55_same_cycle", lo_o, 32'h1234_5678);
`endif
    tick;
    op_valid_i = 1'b0;
    settle;
    chk("mtlo55_after", lo_o, 32'h55);

    // Reset during RUN, then MULTU 3*5
    op_valid_i = 1'b1; op_i = MULT; src_a_i = 32'd7; src_b_i = 32'd9;
    settle;
    tick;
    op_valid_i = 1'b0; rst = 1'b0;
    settle;
    chk("rrun_annul", unit_annul_o, 0);
    tick;
    rst = 1'b1;
    settle;
    chk("rrun_busy", busy_o, 0);
    chk("rrun_hi", hi_o, 0);
    chk("rrun_lo", lo_o, 0);
    chk("rrun_ua", unit_a_o, 0);
    chk("rrun_udiv", unit_div_o, 0);
    chk("rrun_usigned", unit_signed_o, 0);
    chk("rrun_we", hilo_we_o, 0);
    op_valid_i = 1'b1; op_i = MULTU; src_a_i = 32'd3; src_b_i = 32'd5;
    settle;
    chk("multu_start", unit_start_o, 1);
    tick;
    unit_ready_i = 1'b1; unit_result_i = 64'd15;
    settle;
    chk("multu_unsigned", unit_signed_o, 0);
    chk("multu_ua", unit_a_o, 3);
    chk("multu_ub", unit_b_o, 5);
    tick;
    unit_ready_i = 1'b0; unit_result_i = '0;
    settle;
    chk("multu_done_busy", busy_o, 0);
    tick;
    op_valid_i = 1'b0;
    settle;
    chk("multu_lo", lo_o, 15);
    chk("multu_hi", hi_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
